// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller:
// stall encodings, bus widths, FSM states and the stall-vector helper.
package pipe_ctrl_pkg;

    localparam int INST_ADDR_BUS = 32;

    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic BRANCH_ENABLE = 1'b1;

    localparam logic [INST_ADDR_BUS-1:0] ZERO_WORD = '0;

    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;
    localparam int STALL_W     = 5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_BR_PEND = 1'b1
    } br_state_e;

    // A request freezes its own stage and everything upstream of it.
    function automatic logic [STALL_W-1:0] stall_vec(
        input logic r_if,
        input logic r_id,
        input logic r_ex,
        input logic r_mem
    );
        logic [STALL_W-1:0] v;
        logic               s_ex;
        logic               s_id;
        logic               s_if;
        s_ex = r_mem | r_ex;
        s_id = s_ex | r_id;
        s_if = s_id | r_if;
        v = {STALL_W{NO_STOP}};
        v[STALL_MEMWB] = r_mem ? STOP : NO_STOP;
        v[STALL_EXMEM] = s_ex ? STOP : NO_STOP;
        v[STALL_IDEX]  = s_id ? STOP : NO_STOP;
        v[STALL_IFID]  = s_if ? STOP : NO_STOP;
        v[STALL_PC]    = s_if ? STOP : NO_STOP;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, branch redirect hand-off to
// pc_reg with hold-while-frozen, and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stallreq_if_i,
    input  logic                     stallreq_id_i,
    input  logic                     stallreq_ex_i,
    input  logic                     stallreq_mem_i,
    input  logic                     ex_branch_flag_i,
    input  logic [INST_ADDR_BUS-1:0] ex_branch_addr_i,
    input  logic                     cnt_clr_i,
    output logic [STALL_W-1:0]       stalled_o,
    output logic                     pc_branch_o,
    output logic [INST_ADDR_BUS-1:0] pc_branch_addr_o,
    output logic                     if_flush_o,
    output logic                     br_pending_o,
    output logic [CNT_W-1:0]         stall_cycles_o
);

    br_state_e                state_q;
    br_state_e                state_d;
    logic [INST_ADDR_BUS-1:0] br_addr_q;
    logic [INST_ADDR_BUS-1:0] br_addr_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     pc_free;

    assign stalled_o = stall_vec(stallreq_if_i, stallreq_id_i,
                                 stallreq_ex_i, stallreq_mem_i);
    assign pc_free   = (stalled_o[STALL_PC] == NO_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            br_addr_q <= ZERO_WORD;
        end else begin
            state_q   <= state_d;
            br_addr_q <= br_addr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        br_addr_d        = br_addr_q;
        pc_branch_o      = ~BRANCH_ENABLE;
        pc_branch_addr_o = ZERO_WORD;
        if_flush_o       = 1'b0;
        br_pending_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_branch_flag_i) begin
                    if_flush_o = 1'b1;
                    if (pc_free) begin
                        pc_branch_o      = BRANCH_ENABLE;
                        pc_branch_addr_o = ex_branch_addr_i;
                    end else begin
                        br_addr_d = ex_branch_addr_i;
                        state_d   = ST_BR_PEND;
                    end
                end
            end
            ST_BR_PEND: begin
                if_flush_o   = 1'b1;
                br_pending_o = 1'b1;
                // The newest redirect supersedes the held one.
                if (ex_branch_flag_i && pc_free) begin
                    pc_branch_o      = BRANCH_ENABLE;
                    pc_branch_addr_o = ex_branch_addr_i;
                    state_d          = ST_IDLE;
                end else if (ex_branch_flag_i) begin
                    br_addr_d = ex_branch_addr_i;
                end else if (pc_free) begin
                    pc_branch_o      = BRANCH_ENABLE;
                    pc_branch_addr_o = br_addr_q;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if ((|stalled_o) && !(&cnt_q)) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// checked against a redirect/stall model built from the block's rules.
module tb_pipe_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          req_if;
    logic          req_id;
    logic          req_ex;
    logic          req_mem;
    logic          br_flag;
    logic [31:0]   br_addr;
    logic          cnt_clr;
    logic [4:0]    stalled;
    logic          pc_branch;
    logic [31:0]   pc_addr;
    logic          if_flush;
    logic          br_pending;
    logic [CW-1:0] stall_cycles;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stallreq_if_i    (req_if),
        .stallreq_id_i    (req_id),
        .stallreq_ex_i    (req_ex),
        .stallreq_mem_i   (req_mem),
        .ex_branch_flag_i (br_flag),
        .ex_branch_addr_i (br_addr),
        .cnt_clr_i        (cnt_clr),
        .stalled_o        (stalled),
        .pc_branch_o      (pc_branch),
        .pc_branch_addr_o (pc_addr),
        .if_flush_o       (if_flush),
        .br_pending_o     (br_pending),
        .stall_cycles_o   (stall_cycles)
    );

    typedef struct packed {
        logic [4:0]    stalled;
        logic          pcb;
        logic [31:0]   addr;
        logic          flush;
        logic          pend;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   cyc;

    bit          rst_v;
    bit          m_pend;
    logic [31:0] m_addr;
    int          m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (stalled !== e.stalled || pc_branch !== e.pcb ||
                pc_addr !== e.addr || if_flush !== e.flush ||
                br_pending !== e.pend || stall_cycles !== e.cnt) begin
                miscompares++;
                $display("FAIL cycle%0d got st=%b pcb=%b a=%h fl=%b pd=%b c=%0d exp st=%b pcb=%b a=%h fl=%b pd=%b c=%0d",
                         cyc, stalled, pc_branch, pc_addr, if_flush,
                         br_pending, stall_cycles, e.stalled, e.pcb,
                         e.addr, e.flush, e.pend, e.cnt);
            end
        end
    end

    function automatic logic [4:0] exp_stall(bit a_if, bit a_id,
                                             bit a_ex, bit a_mem);
        if (a_mem) return 5'b11111;
        if (a_ex)  return 5'b01111;
        if (a_id)  return 5'b00111;
        if (a_if)  return 5'b00011;
        return 5'b00000;
    endfunction

    task automatic step(bit a_if, bit a_id, bit a_ex, bit a_mem,
                        bit a_br, logic [31:0] a_addr, bit a_clr);
        exp_t e;
        bit   free;
        @(posedge clk);
        #1;
        rst_n   = rst_v;
        req_if  = a_if;
        req_id  = a_id;
        req_ex  = a_ex;
        req_mem = a_mem;
        br_flag = a_br;
        br_addr = a_addr;
        cnt_clr = a_clr;
        e = '0;
        if (!rst_v) begin
            e.stalled = exp_stall(a_if, a_id, a_ex, a_mem);
            m_pend = 0;
            m_addr = '0;
            m_cnt  = 0;
        end else begin
            e.stalled = exp_stall(a_if, a_id, a_ex, a_mem);
            free      = (e.stalled == 5'b0);
            e.flush   = a_br | m_pend;
            e.pend    = m_pend;
            e.cnt     = m_cnt[CW-1:0];
            if (a_br && free) begin
                e.pcb  = 1'b1;
                e.addr = a_addr;
                m_pend = 0;
            end else if (a_br) begin
                m_pend = 1;
                m_addr = a_addr;
            end else if (m_pend && free) begin
                e.pcb  = 1'b1;
                e.addr = m_addr;
                m_pend = 0;
            end
            if (a_clr)
                m_cnt = 0;
            else if (e.stalled != 0 && m_cnt < CMAX)
                m_cnt++;
        end
        sb.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, $urandom, 0);
    endtask

    task automatic reset_now();
        exp_t e;
        @(posedge clk);
        #1;
        req_if  = 0;
        req_id  = 0;
        req_ex  = 0;
        req_mem = 0;
        br_flag = 0;
        cnt_clr = 0;
        rst_n   = 0;
        rst_v   = 0;
        #1;
        vectors++;
        if (stalled !== 5'b0 || pc_branch !== 1'b0 ||
            pc_addr !== 32'b0 || if_flush !== 1'b0 ||
            br_pending !== 1'b0 || stall_cycles !== '0) begin
            miscompares++;
            $display("FAIL async_reset got pcb=%b a=%h fl=%b pd=%b c=%0d exp all zero",
                     pc_branch, pc_addr, if_flush, br_pending, stall_cycles);
        end
        m_pend = 0;
        m_addr = '0;
        m_cnt  = 0;
        e = '0;
        sb.push_back(e);
    endtask

    initial begin
        bit last_br;
        bit b;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n   = 0;
        req_if  = 0;
        req_id  = 0;
        req_ex  = 0;
        req_mem = 0;
        br_flag = 0;
        br_addr = '0;
        cnt_clr = 0;
        rst_v   = 0;
        m_pend  = 0;
        m_addr  = '0;
        m_cnt   = 0;

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        rst_v = 1;
        idle(1);

        step(1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);

        step(0, 0, 0, 0, 1, 32'h100, 0);
        idle(2);

        step(1, 0, 0, 0, 1, 32'h200, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        idle(3);

        step(1, 0, 0, 0, 1, 32'h200, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 1, 32'h300, 0);
        step(0, 1, 0, 0, 0, 32'h0, 0);
        idle(3);

        step(0, 0, 1, 0, 1, 32'h400, 0);
        step(0, 0, 0, 0, 1, 32'h500, 0);
        idle(1);

        step(1, 0, 0, 0, 1, 32'h600, 0);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        reset_now();
        step(0, 0, 0, 0, 0, 0, 0);
        rst_v = 1;
        idle(3);

        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1);
        idle(2);

        last_br = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_now();
                rst_v = 1;
                last_br = 0;
            end else begin
                b = !last_br && ($urandom_range(0, 5) == 0);
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 7) == 0,
                     b, $urandom,
                     $urandom_range(0, 31) == 0);
                last_br = b;
            end
        end
        idle(1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage core. It turns per-stage stall requests into the 5-bit `stalled` vector consumed by the pipeline registers (`if_id`, `id_ex`, `ex_mem`, `mem_wb`) and by `pc_reg`. It also forwards the EX-stage branch redirect to `pc_reg`: if the redirect arrives while the PC is frozen, the target is held until the PC can accept it. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
Parameters:
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stallreq_if_i`  in  1  fetch bus not ready.
- `stallreq_id_i`  in  1  load-use hazard detected in ID.
- `stallreq_ex_i`  in  1  multi-cycle EX operation busy.
- `stallreq_mem_i`  in  1  data bus not ready.
- `ex_branch_flag_i`  in  1  EX redirect, single-cycle pulse.
- `ex_branch_addr_i`  in  32  redirect target.
- `cnt_clr_i`  in  1  synchronous clear of the stall counter.
- `stalled_o`  out  5  stall vector, 1 = Stop: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- `pc_branch_o`  out  1  redirect to `pc_reg`.
- `pc_branch_addr_o`  out  32  redirect target to `pc_reg`.
- `if_flush_o`  out  1  IF/ID must load a bubble.
- `br_pending_o`  out  1  a held redirect is waiting.
- `stall_cycles_o`  out  CNT_W  saturating count of cycles with `stalled_o != 0`.

## Operation
- `stalled_o` is combinational from the requests. The highest requesting stage wins:
  - mem → 5'b11111
  - ex → 5'b01111
  - id → 5'b00111
  - if → 5'b00011
  - none → 5'b00000
- Every stage downstream of the requester keeps advancing. The pipeline registers insert their own bubbles.
- The FSM has two states: IDLE and BR_PEND.
- IDLE, branch pulse with `stalled_o[0]==0`:
  - Same cycle: `pc_branch_o=1`, `pc_branch_addr_o=ex_branch_addr_i`, `if_flush_o=1`.
  - State stays IDLE.
- IDLE, branch pulse with `stalled_o[0]==1`:
  - Latch the target into `br_addr_q`. Next state is BR_PEND.
  - `if_flush_o=1` in the pulse cycle.
- BR_PEND:
  - `if_flush_o=1` and `br_pending_o=1` in every cycle.
  - First cycle with `stalled_o[0]==0`: `pc_branch_o=1` with `br_addr_q`, then return to IDLE.
  - A new branch pulse in BR_PEND overwrites `br_addr_q`. The newest target wins, and if the PC is free that cycle the new target is driven directly.
- Stall counter:
  - `cnt_clr_i` clears it and has priority over increment.
  - Otherwise it increments when `stalled_o != 0` and saturates at all-ones.

## Timing
- Reset values: `stalled_o=0` (no requests asserted), `pc_branch_o=0`, `pc_branch_addr_o=0`, `if_flush_o=0`, `br_pending_o=0`, `stall_cycles_o=0`. FSM resets to IDLE and `br_addr_q` to 0.
- `stalled_o`: zero-cycle latency from the requests.
- Redirect latency: 0 cycles when the PC is free. Otherwise it is driven in the first cycle the PC becomes free, with `stalled_o[0]` deasserted in that same cycle.
- `pc_branch_addr_o` is 0 whenever `pc_branch_o=0`.
- Reset asserted in BR_PEND discards the pending target; no redirect is issued after reset.
- The counter updates one cycle after the stalled cycle is observed.

## Structure
- Shared package or defines file (`yadan_defs.v`): `Stop`/`NoStop`, `BranchEnable`, `ZeroWord`, `InstAddrBus`, stall bit indices (`STALL_PC` … `STALL_MEMWB`), FSM state encodings.
- No sub-module is needed. The counter is inline; a generic `sat_counter` is optional.

## Test plan
- Requests if=1 and ex=1 together → `stalled_o=5'b01111`. Then mem=1 alone → `5'b11111`. Then all 0 → `5'b00000`.
- Branch pulse to 0x0000_0100, no stall → same cycle `pc_branch_o=1`, addr 0x100, `if_flush_o=1`; next cycle all three 0.
- Branch to 0x200 while `stallreq_if_i=1` for 3 cycles → `br_pending_o=1` for 3 cycles, then `pc_branch_o=1` with 0x200 in the first unstalled cycle, then IDLE.
- In BR_PEND holding 0x200, a second pulse to 0x300 (PC still stalled) → the later redirect carries 0x300 only, issued exactly once.
- Assert `rst_n=0` mid-BR_PEND → outputs go to reset values immediately; after release with no stall, no redirect appears.
- With `CNT_W=4`, stall for 20 cycles → counter reads 15 and holds. `cnt_clr_i` together with a stall → reads 0 next cycle.
